// File: rtl/mdio_master.sv
// Clause-22 MDIO initiator: turns one Wishbone classic request into a full MDC/MDIO frame
// and reports completion with a single-cycle ack (or err when a read sees no PHY).
module mdio_master #(
    parameter int unsigned MDC_DIV       = 25,
    parameter int unsigned PREAMBLE_BITS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_cyc,
    input  logic        wb_stb,
    input  logic        wb_we,
    input  logic [9:0]  wb_addr,
    input  logic [15:0] wb_data_write,
    output logic [15:0] wb_data_read,
    output logic        wb_ack,
    output logic        wb_err,
    output logic        mdc,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_oe
);
    localparam int unsigned   CW       = (MDC_DIV > 1) ? $clog2(MDC_DIV) : 1;
    localparam logic [CW-1:0] DIV_LAST = CW'(MDC_DIV - 1);
    localparam logic [5:0]    PRE_LAST = 6'((PREAMBLE_BITS > 0) ? PREAMBLE_BITS - 1 : 0);

    typedef enum logic [2:0] {
        StIdle,
        StPreamble,
        StHeader,
        StTurnaround,
        StData,
        StDone
    } state_e;

    state_e        state_q;
    logic [CW-1:0] div_cnt_q;
    logic [5:0]    bit_cnt_q;
    logic [31:0]   tx_sr_q;
    logic [15:0]   rx_sr_q;
    logic          we_q;
    logic          ta_q;
    logic          abandon_q;

    logic          req;
    logic [31:0]   frame;

    assign req = wb_cyc && wb_stb && !wb_ack && !wb_err;
    // Everything after the preamble; read TA/data slots are ones since the line is released.
    assign frame = {2'b01, wb_we ? 2'b01 : 2'b10, wb_addr, wb_we ? 2'b10 : 2'b11,
                    wb_we ? wb_data_write : 16'hffff};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            div_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            tx_sr_q      <= '0;
            rx_sr_q      <= '0;
            we_q         <= 1'b0;
            ta_q         <= 1'b1;
            abandon_q    <= 1'b0;
            mdc          <= 1'b0;
            mdio_o       <= 1'b1;
            mdio_oe      <= 1'b0;
            wb_ack       <= 1'b0;
            wb_err       <= 1'b0;
            wb_data_read <= 16'hffff;
        end else begin
            wb_ack <= 1'b0;
            wb_err <= 1'b0;
            // Once the master walks away, this frame never gets a pulse.
            if (state_q != StIdle && !wb_cyc) abandon_q <= 1'b1;
            case (state_q)
                StIdle: begin
                    if (req) begin
                        we_q      <= wb_we;
                        tx_sr_q   <= frame;
                        abandon_q <= 1'b0;
                        div_cnt_q <= '0;
                        bit_cnt_q <= '0;
                        mdc       <= 1'b0;
                        mdio_oe   <= 1'b1;
                        if (PREAMBLE_BITS == 0) begin
                            state_q <= StHeader;
                            mdio_o  <= frame[31];
                        end else begin
                            state_q <= StPreamble;
                            mdio_o  <= 1'b1;
                        end
                    end
                end
                StDone: state_q <= StIdle;
                default: begin
                    if (div_cnt_q != DIV_LAST) begin
                        div_cnt_q <= div_cnt_q + 1'b1;
                    end else begin
                        div_cnt_q <= '0;
                        if (!mdc) begin
                            mdc <= 1'b1;
                            if (state_q == StTurnaround && bit_cnt_q == 6'd1) ta_q <= mdio_i;
                            if (state_q == StData) rx_sr_q <= {rx_sr_q[14:0], mdio_i};
                        end else begin
                            mdc       <= 1'b0;
                            bit_cnt_q <= bit_cnt_q + 6'd1;
                            if (state_q != StPreamble) begin
                                tx_sr_q <= tx_sr_q << 1;
                                mdio_o  <= tx_sr_q[30];
                            end
                            case (state_q)
                                StPreamble: begin
                                    if (bit_cnt_q == PRE_LAST) begin
                                        state_q   <= StHeader;
                                        bit_cnt_q <= '0;
                                        mdio_o    <= tx_sr_q[31];
                                    end
                                end
                                StHeader: begin
                                    if (bit_cnt_q == 6'd13) begin
                                        state_q   <= StTurnaround;
                                        bit_cnt_q <= '0;
                                        mdio_oe   <= we_q;
                                    end
                                end
                                StTurnaround: begin
                                    if (bit_cnt_q == 6'd1) begin
                                        state_q   <= StData;
                                        bit_cnt_q <= '0;
                                    end
                                end
                                StData: begin
                                    if (bit_cnt_q == 6'd15) begin
                                        state_q <= StDone;
                                        mdio_oe <= 1'b0;
                                        mdio_o  <= 1'b1;
                                        if (!we_q) wb_data_read <= ta_q ? 16'hffff : rx_sr_q;
                                        if (!abandon_q && wb_cyc && wb_stb) begin
                                            if (we_q || !ta_q) wb_ack <= 1'b1;
                                            else               wb_err <= 1'b1;
                                        end
                                    end
                                end
                                default: ;
                            endcase
                        end
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mdio_master.sv
// Bench for mdio_master: two configurations, a frame-level reference model, a PHY responder
// and a scoreboard that checks wire bits, completion timing and read data.
module tb_mdio_master;
    localparam int unsigned D0 = 2;
    localparam int unsigned P0 = 32;
    localparam int unsigned D1 = 3;
    localparam int unsigned P1 = 0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        wb_cyc [2];
    logic        wb_stb [2];
    logic        wb_we [2];
    logic [9:0]  wb_addr [2];
    logic [15:0] wb_data_write [2];
    logic [15:0] wb_data_read [2];
    logic        wb_ack [2];
    logic        wb_err [2];
    logic        mdc [2];
    logic        mdio_i [2];
    logic        mdio_o [2];
    logic        mdio_oe [2];
    logic        phy_en [2];
    logic        phy_val [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        // Pad with pull-up: master drive wins, else PHY drive, else idle high.
        assign mdio_i[g] = mdio_oe[g] ? mdio_o[g] : (phy_en[g] ? phy_val[g] : 1'b1);
        mdio_master #(
            .MDC_DIV      ((g == 0) ? D0 : D1),
            .PREAMBLE_BITS((g == 0) ? P0 : P1)
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .wb_cyc       (wb_cyc[g]),
            .wb_stb       (wb_stb[g]),
            .wb_we        (wb_we[g]),
            .wb_addr      (wb_addr[g]),
            .wb_data_write(wb_data_write[g]),
            .wb_data_read (wb_data_read[g]),
            .wb_ack       (wb_ack[g]),
            .wb_err       (wb_err[g]),
            .mdc          (mdc[g]),
            .mdio_i       (mdio_i[g]),
            .mdio_o       (mdio_o[g]),
            .mdio_oe      (mdio_oe[g])
        );
    end

    typedef struct {
        int          kind;  // 0 none, 1 ack, 2 err
        logic [15:0] data;
        longint      due;
    } pulse_t;

    typedef struct {
        logic [63:0] bits;
        logic [63:0] oe;
        int          nbits;
        bit          present;
        logic [15:0] rdata;
    } frame_t;

    pulse_t      pq [2][$];
    frame_t      fq [2][$];
    logic [15:0] rd_model [2];
    longint      idle_from [2];
    longint      cyc_n = 0;
    int          checks = 0;
    int          errors = 0;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    function automatic int divof(input int g);
        return (g == 0) ? int'(D0) : int'(D1);
    endfunction

    function automatic int preof(input int g);
        return (g == 0) ? int'(P0) : int'(P1);
    endfunction

    // Model: issue a request and record the expected frame, completion cycle and read data.
    task automatic start(input int g, input bit we, input logic [9:0] addr,
                         input logic [15:0] wd, input bit present, input logic [15:0] rdata,
                         input bit abandon);
        pulse_t      e;
        frame_t      f;
        longint      acc;
        logic [31:0] body;
        int          p;
        p   = preof(g);
        acc = cyc_n + 1;
        if (idle_from[g] > acc) acc = idle_from[g];
        e.due        = acc + longint'((p + 32) * 2 * divof(g));
        idle_from[g] = e.due + 2;
        if (!we) rd_model[g] = present ? rdata : 16'hffff;
        e.data = rd_model[g];
        e.kind = abandon ? 0 : ((we || present) ? 1 : 2);
        body   = {2'b01, we ? 2'b01 : 2'b10, addr, 2'b10, wd};
        f.bits = '0;
        f.oe   = '0;
        f.nbits   = p + 32;
        f.present = present && !we;
        f.rdata   = rdata;
        for (int i = 0; i < p; i++) begin
            f.bits[i] = 1'b1;
            f.oe[i]   = 1'b1;
        end
        for (int j = 0; j < 32; j++) begin
            f.bits[p + j] = body[31 - j];
            f.oe[p + j]   = we || (j < 14);
        end
        pq[g].push_back(e);
        fq[g].push_back(f);
        wb_cyc[g]        = 1'b1;
        wb_stb[g]        = 1'b1;
        wb_we[g]         = we;
        wb_addr[g]       = addr;
        wb_data_write[g] = wd;
    endtask

    task automatic wait_done(input int g, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(wb_ack[g] || wb_err[g]) && n < 1000);
        if (!(wb_ack[g] || wb_err[g])) begin
            checks++;
            errors++;
            $display("FAIL %s: no ack/err within %0d cycles, required a completion", name, n);
        end
        wb_cyc[g] = 1'b0;
        wb_stb[g] = 1'b0;
    endtask

    // Monitor, responder and scoreboard for both instances.
    initial begin : monitor
        logic        prev [2];
        int          idx [2];
        frame_t      cur [2];
        logic [63:0] ob [2];
        logic [63:0] oo [2];
        pulse_t      e;
        int          n;
        int          p;
        for (int g = 0; g < 2; g++) begin
            prev[g] = 1'b0;
            idx[g] = 0;
            phy_en[g] = 1'b0;
            phy_val[g] = 1'b1;
            ob[g] = '0;
            oo[g] = '0;
        end
        forever begin
            @(negedge clk);
            for (int g = 0; g < 2; g++) begin
                if (rst) begin
                    pq[g].delete();
                    fq[g].delete();
                    idx[g] = 0;
                    prev[g] = 1'b0;
                    phy_en[g] = 1'b0;
                end else begin
                    if (pq[g].size() > 0 && pq[g][0].due == cyc_n) begin
                        e = pq[g].pop_front();
                        checks++;
                        if (wb_ack[g] !== (e.kind == 1) || wb_err[g] !== (e.kind == 2)) begin
                            errors++;
                            $display("FAIL pulse[%0d] cyc %0d: ack=%b err=%b, required ack=%b err=%b",
                                     g, cyc_n, wb_ack[g], wb_err[g], e.kind == 1, e.kind == 2);
                        end
                        checks++;
                        if (wb_data_read[g] !== e.data) begin
                            errors++;
                            $display("FAIL rdata[%0d] cyc %0d: got %h, required %h",
                                     g, cyc_n, wb_data_read[g], e.data);
                        end
                    end else if (wb_ack[g] || wb_err[g]) begin
                        checks++;
                        errors++;
                        $display("FAIL stray_pulse[%0d] cyc %0d: ack=%b err=%b, required none",
                                 g, cyc_n, wb_ack[g], wb_err[g]);
                    end
                    if (mdc[g] && !prev[g]) begin
                        if (idx[g] == 0) begin
                            if (fq[g].size() == 0) begin
                                checks++;
                                errors++;
                                $display("FAIL stray_frame[%0d] cyc %0d: mdc toggling, required idle",
                                         g, cyc_n);
                                cur[g].bits = '0;
                                cur[g].oe = '0;
                                cur[g].nbits = preof(g) + 32;
                                cur[g].present = 1'b0;
                                cur[g].rdata = '0;
                            end else begin
                                cur[g] = fq[g].pop_front();
                            end
                            ob[g] = '0;
                            oo[g] = '0;
                        end
                        ob[g][idx[g]] = mdio_o[g];
                        oo[g][idx[g]] = mdio_oe[g];
                        idx[g]++;
                        if (idx[g] == cur[g].nbits) begin
                            checks++;
                            if ((ob[g] & cur[g].oe) !== (cur[g].bits & cur[g].oe)) begin
                                errors++;
                                $display("FAIL wire_bits[%0d]: got %h, required %h", g,
                                         ob[g] & cur[g].oe, cur[g].bits & cur[g].oe);
                            end
                            checks++;
                            if (oo[g] !== cur[g].oe) begin
                                errors++;
                                $display("FAIL wire_oe[%0d]: got %h, required %h",
                                         g, oo[g], cur[g].oe);
                            end
                            idx[g] = 0;
                        end
                        n = idx[g];
                        p = preof(g);
                        if (n != 0 && cur[g].present && n == p + 15) begin
                            phy_en[g] = 1'b1;
                            phy_val[g] = 1'b0;
                        end else if (n != 0 && cur[g].present && n >= p + 16) begin
                            phy_en[g] = 1'b1;
                            phy_val[g] = cur[g].rdata[15 - (n - p - 16)];
                        end else begin
                            phy_en[g] = 1'b0;
                        end
                    end
                    prev[g] = mdc[g];
                end
            end
        end
    end

    initial begin : stimulus
        logic [9:0]  a;
        logic [15:0] d;
        logic [15:0] r;
        for (int g = 0; g < 2; g++) begin
            wb_cyc[g] = 1'b0;
            wb_stb[g] = 1'b0;
            wb_we[g] = 1'b0;
            wb_addr[g] = '0;
            wb_data_write[g] = '0;
            rd_model[g] = 16'hffff;
            idle_from[g] = 0;
        end
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            checks++;
            if ({mdc[g], mdio_o[g], mdio_oe[g], wb_ack[g], wb_err[g], wb_data_read[g]} !==
                {5'b01000, 16'hffff}) begin
                errors++;
                $display("FAIL reset[%0d]: mdc/o/oe/ack/err=%b%b%b%b%b rdata=%h, required 01000 ffff",
                         g, mdc[g], mdio_o[g], mdio_oe[g], wb_ack[g], wb_err[g], wb_data_read[g]);
            end
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);

        start(0, 1'b1, {5'd1, 5'd0}, 16'h1200, 1'b0, 16'h0, 1'b0);
        wait_done(0, "wr_1200");
        repeat (2) @(negedge clk);
        start(0, 1'b0, {5'd3, 5'd2}, 16'h0, 1'b1, 16'h796d, 1'b0);
        wait_done(0, "rd_796d");
        repeat (2) @(negedge clk);
        start(0, 1'b0, {5'd3, 5'd2}, 16'h0, 1'b0, 16'h0, 1'b0);
        wait_done(0, "rd_absent");
        repeat (2) @(negedge clk);
        start(1, 1'b1, {5'd7, 5'd17}, 16'ha5c3, 1'b0, 16'h0, 1'b0);
        wait_done(1, "wr_nopre");
        repeat (2) @(negedge clk);

        for (int k = 0; k < 10; k++) begin
            a = 10'($urandom);
            d = 16'($urandom);
            r = 16'($urandom);
            start(k % 2, 1'($urandom_range(0, 1)), a, d, $urandom_range(0, 3) != 0, r, 1'b0);
            wait_done(k % 2, "random");
            repeat (1 + $urandom_range(0, 3)) @(negedge clk);
        end

        // Reset in the middle of the header of a write.
        start(0, 1'b1, 10'($urandom), 16'($urandom), 1'b0, 16'h0, 1'b0);
        repeat (150) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({mdc[0], mdio_oe[0], wb_ack[0], wb_err[0]} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid: mdc/oe/ack/err=%b%b%b%b, required 0000",
                     mdc[0], mdio_oe[0], wb_ack[0], wb_err[0]);
        end
        @(negedge clk);
        rst = 1'b0;
        wb_cyc[0] = 1'b0;
        wb_stb[0] = 1'b0;
        for (int g = 0; g < 2; g++) begin
            rd_model[g] = 16'hffff;
            idle_from[g] = 0;
        end
        repeat (2) @(negedge clk);
        start(0, 1'b0, 10'($urandom), 16'h0, 1'b1, 16'($urandom), 1'b0);
        wait_done(0, "after_reset");
        repeat (2) @(negedge clk);

        // Abandoned read followed by a request held while the frame is still on the wire.
        start(1, 1'b0, 10'($urandom), 16'h0, 1'b1, 16'($urandom), 1'b1);
        repeat (60) @(negedge clk);
        wb_cyc[1] = 1'b0;
        wb_stb[1] = 1'b0;
        @(negedge clk);
        start(1, 1'($urandom_range(0, 1)), 10'($urandom), 16'($urandom), 1'b1,
              16'($urandom), 1'b0);
        wait_done(1, "after_abandon");
        repeat (5) @(negedge clk);

        checks++;
        if (pq[0].size() + pq[1].size() + fq[0].size() + fq[1].size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected events outstanding, required 0",
                     pq[0].size() + pq[1].size() + fq[0].size() + fq[1].size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
